fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of data_path. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Fetched words go into a small prefetch buffer, which presents {instr, pc} to decode and register read with a valid/ready handshake. Branch and jump resolution from data_path (beq/bneq/blt/bge/jump) arrives as a redirect that flushes the buffer and restarts fetch.

---
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding data_path.
// Owns the program counter, issues one word read at a time to instruction
// memory over req/ack, and queues fetched words in a DEPTH-entry prefetch
// FIFO that presents {instr, pc} to decode with a valid/ready handshake.
// A redirect (taken branch/jump) flushes the FIFO and restarts fetch.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky fault on a
// misaligned redirect target; when undefined the target is word-aligned).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_drop_addr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_buf_instr [DEPTH];
  logic [31:0]     r_buf_pc    [DEPTH];
  logic            r_instr_valid;
  logic [31:0]     r_instr;
  logic [31:0]     r_instr_pc;

  logic            w_flush;
  logic            w_push;
  logic            w_pop;
  logic            w_fault_next;
  logic            w_slot_free;
  logic [31:0]     w_redir_pc;
  logic [CW-1:0]   w_count_next;
  logic [PW-1:0]   w_rd_ptr_next;
  logic [31:0]     w_head_instr;
  logic [31:0]     w_head_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;
  logic w_fault_set;

  assign w_fault_set  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_fault_next = r_fault || w_fault_set;
  assign w_redir_pc   = redirect_pc;
  assign fetch_fault  = r_fault;

  // Sticky misalignment fault; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end
`else
  logic w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];
  assign w_fault_next    = 1'b0;
  assign w_redir_pc      = {redirect_pc[31:2], 2'b00};
  assign fetch_fault     = 1'b0;
`endif

  // A redirect wins over both a same-cycle ack (data dropped) and a pop.
  assign w_flush = redirect_valid;
  assign w_push  = (r_state == S_REQ) && imem_ack && !redirect_valid;
  assign w_pop   = r_instr_valid && instr_ready && !redirect_valid;

  assign w_count_next  = w_flush ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  assign w_rd_ptr_next = w_flush ? '0 : (w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr);

  // Nothing is outstanding after an ack, so a new request only needs room
  // in the buffer as it will stand after this cycle's push/pop.
  assign w_slot_free = (w_count_next < DEPTH_C) && !w_fault_next;

  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

  // Next FSM state and memory request outputs.
  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    imem_addr    = r_fetch_pc;
    unique case (r_state)
      S_IDLE: begin
        if (w_slot_free) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect_valid && !imem_ack) begin
          w_state_next = S_DROP;
        end else if (imem_ack) begin
          w_state_next = w_slot_free ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        // The abandoned request stays on the bus until memory answers it.
        imem_req  = 1'b1;
        imem_addr = r_drop_addr;
        if (imem_ack) begin
          w_state_next = w_slot_free ? S_REQ : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Head of the FIFO after this cycle; a push into an empty (or emptying)
  // buffer bypasses straight to the head so latency stays one cycle.
  always_comb begin
    w_head_instr = r_buf_instr[w_rd_ptr_next];
    w_head_pc    = r_buf_pc[w_rd_ptr_next];
    if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
      w_head_instr = imem_rdata;
      w_head_pc    = r_fetch_pc;
    end
  end

  // FIFO storage; written on every accepted ack, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata;
      r_buf_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  // FSM, program counter, FIFO pointers and registered head outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_drop_addr   <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_rd_ptr <= w_rd_ptr_next;
      if (w_flush) begin
        r_fetch_pc <= w_redir_pc;
        r_wr_ptr   <= '0;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + PW'(1);
      end
      if ((r_state == S_REQ) && redirect_valid && !imem_ack) begin
        r_drop_addr <= r_fetch_pc;
      end
      r_instr_valid <= (w_count_next != '0);
      if (w_count_next != '0) begin
        r_instr    <= w_head_instr;
        r_instr_pc <= w_head_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Memory model returns ~address as the instruction word, with either a
// zero-wait ack (tied to req) or a fixed wait count before the ack.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;

  logic        ack_tie;
  int          lat;
  int          wcnt = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_fault    (fetch_fault)
  );

  assign imem_rdata = ~imem_addr;
  assign imem_ack   = ack_tie ? imem_req : (imem_req && (wcnt == lat));

  // Cycles the current request has been waiting.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!instr_valid && i < 30) begin
      tick;
      i++;
    end
    chk({tag, " valid"}, {31'b0, instr_valid}, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    ack_tie        = 1'b1;
    lat            = 0;

    // Reset values
    tick;
    tick;
    chk("rst req",   {31'b0, imem_req},    32'h0);
    chk("rst addr",  imem_addr,            32'h0);
    chk("rst valid", {31'b0, instr_valid}, 32'h0);
    chk("rst instr", instr,                32'h0);
    chk("rst pc",    instr_pc,             32'h0);
    chk("rst fault", {31'b0, fetch_fault}, 32'h0);

    // T1: zero-wait memory, consumer always ready -> 1 instr/cycle
    do_reset;
    tick;
    chk("t1 addr0",  imem_addr,            32'h0);
    chk("t1 req0",   {31'b0, imem_req},    32'h1);
    chk("t1 valid0", {31'b0, instr_valid}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("t1 addr",  imem_addr,            32'(4 * k));
      chk("t1 valid", {31'b0, instr_valid}, 32'h1);
      chk("t1 pc",    instr_pc,             32'(4 * (k - 1)));
      chk("t1 instr", instr,                ~32'(4 * (k - 1)));
    end

    // T2: consumer stalled -> buffer fills with pc 0,4 then fetch stops
    instr_ready = 1'b0;
    do_reset;
    tick;
    tick;
    tick;
    chk("t2 req stop", {31'b0, imem_req}, 32'h0);
    for (int k = 0; k < 10; k++) tick;
    chk("t2 req held", {31'b0, imem_req},    32'h0);
    chk("t2 valid",    {31'b0, instr_valid}, 32'h1);
    chk("t2 hold pc",  instr_pc,             32'h0);
    chk("t2 hold ins", instr,                ~32'h0);
    instr_ready = 1'b1;
    tick;
    chk("t2 pc4",   instr_pc,             32'h4);
    chk("t2 v4",    {31'b0, instr_valid}, 32'h1);
    tick;
    chk("t2 pc8",   instr_pc,             32'h8);
    chk("t2 v8",    {31'b0, instr_valid}, 32'h1);
    tick;
    chk("t2 pcC",   instr_pc,             32'hC);

    // T3: 3-cycle ack latency, redirect while request for 0x8 is pending
    ack_tie = 1'b0;
    lat     = 2;
    do_reset;
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h8); i++) tick;
    chk("t3 reach 8", imem_addr,          32'h8);
    chk("t3 no ack",  {31'b0, imem_ack},  32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick;
    redirect_valid = 1'b0;
    chk("t3 drop addr",  imem_addr,            32'h8);
    chk("t3 drop req",   {31'b0, imem_req},    32'h1);
    chk("t3 flushed",    {31'b0, instr_valid}, 32'h0);
    tick;
    chk("t3 drop ack",   {31'b0, imem_ack},    32'h1);
    chk("t3 drop addr2", imem_addr,            32'h8);
    tick;
    chk("t3 new addr",   imem_addr,            32'h40);
    chk("t3 no data",    {31'b0, instr_valid}, 32'h0);
    wait_valid("t3");
    chk("t3 first pc",   instr_pc,             32'h40);
    chk("t3 first ins",  instr,                ~32'h40);

    // T4: redirect in the same cycle as the ack for 0x10
    do_reset;
    for (int i = 0; i < 60 && !(imem_ack && imem_addr == 32'h10); i++) tick;
    chk("t4 reach 10", imem_addr,         32'h10);
    chk("t4 ack",      {31'b0, imem_ack}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick;
    redirect_valid = 1'b0;
    chk("t4 new addr", imem_addr,            32'h100);
    chk("t4 req",      {31'b0, imem_req},    32'h1);
    chk("t4 flushed",  {31'b0, instr_valid}, 32'h0);
    wait_valid("t4");
    chk("t4 first pc", instr_pc,             32'h100);

    // T5: PC wraps at 2^32, then async reset in the middle of a request
    ack_tie = 1'b1;
    lat     = 0;
    do_reset;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    chk("t5 addr top", imem_addr, 32'hFFFF_FFFC);
    tick;
    chk("t5 addr wrap", imem_addr, 32'h0);
    chk("t5 pc top",    instr_pc,  32'hFFFF_FFFC);
    tick;
    chk("t5 addr 4",    imem_addr, 32'h4);
    chk("t5 pc 0",      instr_pc,  32'h0);
    rst = 1'b0;
    #1;
    chk("t5 async req",   {31'b0, imem_req},    32'h0);
    chk("t5 async addr",  imem_addr,            32'h0);
    chk("t5 async valid", {31'b0, instr_valid}, 32'h0);
    chk("t5 async instr", instr,                32'h0);
    chk("t5 async pc",    instr_pc,             32'h0);
    chk("t5 async fault", {31'b0, fetch_fault}, 32'h0);
    do_reset;
    tick;
    chk("t5 restart addr", imem_addr,            32'h0);
    chk("t5 restart v",    {31'b0, instr_valid}, 32'h0);
    tick;
    chk("t5 restart pc",   instr_pc,             32'h0);

    // T6: misaligned redirect target 0x42
    do_reset;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick;
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t6 fault",  {31'b0, fetch_fault}, 32'h1);
    chk("t6 req",    {31'b0, imem_req},    32'h0);
    for (int k = 0; k < 5; k++) tick;
    chk("t6 fault held", {31'b0, fetch_fault}, 32'h1);
    chk("t6 req held",   {31'b0, imem_req},    32'h0);
    chk("t6 no valid",   {31'b0, instr_valid}, 32'h0);
`else
    chk("t6 no fault", {31'b0, fetch_fault}, 32'h0);
    chk("t6 addr",     imem_addr,            32'h40);
    chk("t6 req",      {31'b0, imem_req},    32'h1);
    tick;
    chk("t6 pc",       instr_pc,             32'h40);
    chk("t6 instr",    instr,                ~32'h40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
